bcd_seq_converter: RTL
======================

Name: bcd_seq_converter

Overview:
- Sequential double-dabble binary-to-BCD converter with a valid/ready handshake on both input and output.
- Performs one add-3/shift iteration per clock, trading latency for area against the combinational converter.
- Feeds display/readout logic; upstream counters and measurement blocks push binary values in, and the display side pulls BCD digits out.
- Adds parameterised width, an overflow flag and result buffering.

Parameters:
WIDTH, 8, binary input width in bits (>=1)
DIGITS, 3, number of BCD digits produced (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  binary input is valid
in_ready  output  1  converter can accept a new value
binary  input  WIDTH  unsigned value to convert
out_valid  output  1  BCD result available
out_ready  input  1  consumer accepts result
bcd  output  4*DIGITS  result; digit k at bits [4k+3:4k], k=0 is ones
ovf  output  1  value does not fit in DIGITS decimal digits

Behaviour:
- Reset (async, any state, including mid-conversion): state=IDLE, in_ready=1, out_valid=0, bcd=0, ovf=0, internal shift/digit/count registers=0. Any in-flight conversion is discarded.
- FSM states: IDLE, CONV, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at an edge: capture binary into the shift register, clear the working digits and the sticky overflow, load count=WIDTH, go to CONV.
- CONV:
  - in_ready=0, out_valid=0.
  - Each cycle, every working digit >=5 first gets +3 (4-bit, no carry between digits).
  - The {digits, shift register} chain then shifts left by 1; the MSB of the shift register enters bit 0 of digit 0.
  - Bit 3 of the top digit is shifted out; if it is 1, set sticky overflow.
  - count decrements each cycle. On the cycle the WIDTH-th shift completes:
    - load bcd with the final working digits (including that shift);
    - load ovf with the final sticky overflow;
    - go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0; bcd and ovf are stable.
  - On out_ready at an edge, go to IDLE. No overlap with the next input: in_valid is ignored in HOLD.
- Latency: an input accepted at edge N gives out_valid=1 after edge N+WIDTH, i.e. exactly WIDTH cycles in CONV.
- Throughput: at best one result per WIDTH+2 cycles (accept, WIDTH shifts, handoff).
- bcd and ovf change only on the CONV->HOLD transition or reset. They keep the last result through IDLE and the next CONV.
- Overflow:
  - Lower digits are always the value mod 10^DIGITS.
  - ovf=1 iff binary >= 10^DIGITS.
  - With the defaults, ovf is always 0 (max 255).
- Input data is sampled only at the accepting edge. Changes to binary at any other time have no effect.
- in_valid and out_ready may be asserted in any state; they are acted on only in IDLE and HOLD respectively.
- Width rules:
  - Add-3 is applied before each shift, including the first.
  - Digits are 4-bit, counter width is clog2(WIDTH+1), and there are no combinational paths from inputs to outputs.

Test Plan:
- Defaults: binary=255, in_valid pulse, out_ready=1 -> out_valid rises 8 cycles after accept; bcd=12'h255, ovf=0; in_ready returns 1 the next cycle.
- Defaults: sweep binary 0..255, each checked against a reference model -> bcd equals the decimal digits of the input (0->12'h000, 99->12'h099, 100->12'h100); ovf=0 throughout.
- Back-pressure:
  - convert 42, hold out_ready=0 for 20 cycles -> out_valid stays 1 and bcd stays 12'h042;
  - drive in_valid=1 with binary=7 during that hold -> ignored, in_ready=0;
  - after out_ready=1 -> IDLE, then 7 is accepted and converts to 12'h007.
- Reset mid-operation: assert rst at CONV cycle 4 of converting 200 -> outputs immediately 0, state IDLE; next conversion of 13 gives 12'h013 with correct latency.
- DIGITS=2, WIDTH=8:
  - 200 -> bcd=8'h00, ovf=1;
  - 255 -> 8'h55, ovf=1;
  - 99 -> 8'h99, ovf=0;
  - ovf clears on the next accepted in-range value.
- WIDTH=12, DIGITS=4: 4095 -> bcd=16'h4095, out_valid 12 cycles after accept; back-to-back inputs with out_ready tied 1 -> one result every 14 cycles.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// -----------------------------------------------------------------------------
// bcd_seq_converter
//
// Sequential double-dabble binary-to-BCD converter. One add-3/shift step is
// performed per clock, so a WIDTH-bit value takes WIDTH cycles to convert.
// Input and output both use a valid/ready handshake. The last result (bcd, ovf)
// is held until the next conversion completes.
//
// Parameters:
//   WIDTH   binary input width in bits (>= 1)
//   DIGITS  number of BCD digits produced (>= 1)
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   binary input is valid
//   in_ready   converter can accept a new value (high only in IDLE)
//   binary     unsigned value to convert, sampled only at the accepting edge
//   out_valid  BCD result available (high only in HOLD)
//   out_ready  consumer accepts the result
//   bcd        result; digit k occupies bits [4k+3:4k], k = 0 is the ones digit
//   ovf        value does not fit in DIGITS decimal digits
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module bcd_seq_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      binary,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Double-dabble correction for a single digit: values of 5 and above get +3
  // so that the following left shift carries into the next digit correctly.
  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Apply the correction to every digit independently (no carries between
  // digits; a corrected digit never exceeds 4'd12).
  function automatic logic [DW-1:0] adjust_digits(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = add3(d[4*k +: 4]);
    end
    return r;
  endfunction

  // Registered state
  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [DW-1:0]    digits;
  logic [CW-1:0]    count;
  logic             sticky;

  // Next-state values
  state_t           next_state;
  logic [WIDTH-1:0] next_shift;
  logic [DW-1:0]    next_digits;
  logic [CW-1:0]    next_count;
  logic             next_sticky;
  logic [DW-1:0]    next_bcd;
  logic             next_ovf;
  logic             next_in_ready;
  logic             next_out_valid;

  // One iteration of the datapath
  logic [DW-1:0]    adj_digits;
  logic [DW-1:0]    shifted_digits;
  logic [WIDTH-1:0] shifted_sr;
  logic             shift_out;

  // Combinational add-3 then shift of the {digits, shift_reg} chain.
  always_comb begin
    adj_digits     = adjust_digits(digits);
    // The MSB of the binary shift register enters bit 0 of the ones digit.
    shifted_digits = {adj_digits[DW-2:0], shift_reg[WIDTH-1]};
    shifted_sr     = shift_reg << 1;
    // Bit 3 of the corrected top digit leaves the chain: the value has grown
    // past what DIGITS digits can represent.
    shift_out      = adj_digits[DW-1];
  end

  // Next-state and next-output logic for the IDLE/CONV/HOLD controller.
  always_comb begin
    next_state  = state;
    next_shift  = shift_reg;
    next_digits = digits;
    next_count  = count;
    next_sticky = sticky;
    next_bcd    = bcd;
    next_ovf    = ovf;

    case (state)
      IDLE: begin
        if (in_valid) begin
          next_shift  = binary;
          next_digits = '0;
          next_sticky = 1'b0;
          next_count  = CW'(WIDTH);
          next_state  = CONV;
        end else begin
          next_state  = IDLE;
        end
      end

      CONV: begin
        next_shift  = shifted_sr;
        next_digits = shifted_digits;
        next_sticky = sticky | shift_out;
        next_count  = count - CW'(1);
        // The last shift is this cycle; publish the result including it.
        // A count of zero cannot occur in CONV but is treated as done as well.
        if (count <= CW'(1)) begin
          next_bcd   = shifted_digits;
          next_ovf   = sticky | shift_out;
          next_state = HOLD;
        end else begin
          next_state = CONV;
        end
      end

      HOLD: begin
        // in_valid is deliberately ignored here; a new value is only taken
        // once the result has been handed off and the FSM is back in IDLE.
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = HOLD;
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so they line up
    // with the state register without any input-to-output path.
    next_in_ready  = (next_state == IDLE);
    next_out_valid = (next_state == HOLD);
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Working datapath registers: binary shift register, digits, count, sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      digits    <= '0;
      count     <= '0;
      sticky    <= 1'b0;
    end else begin
      shift_reg <= next_shift;
      digits    <= next_digits;
      count     <= next_count;
      sticky    <= next_sticky;
    end
  end

  // Result and handshake output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      bcd       <= next_bcd;
      ovf       <= next_ovf;
      in_ready  <= next_in_ready;
      out_valid <= next_out_valid;
    end
  end

endmodule
